// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
// State encoding is exported so checkers can bind to the FSM directly.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_READ  = 2'd1,
    MEM_READ = 2'd2,
    WRITE    = 2'd3
  } arb_state_e;

  localparam logic [31:0] IO_BASE   = 32'h0003_0000;

  localparam logic [2:0]  LEN_B     = 3'd1;
  localparam logic [2:0]  LEN_H     = 3'd2;
  localparam logic [2:0]  LEN_W     = 3'd4;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// Collects RAM read bytes into a little-endian word, one byte lane per
// transfer; cleared when a new transaction is granted.
module mem_arbiter_byte_assembler
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic        capture,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  output logic [31:0] word_merged
);

  logic [31:0] word;

  // word_merged includes the byte arriving this cycle, so the FSM can hand
  // out the complete word on the same edge that captures the last byte.
  always_comb begin
    word_merged = word;
    if (capture) begin
      word_merged[8*idx +: 8] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      word <= ZeroWord;
    end else if (en) begin
      if (clear) begin
        word <= ZeroWord;
      end else begin
        word <= word_merged;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the load/store
// unit, serialising each access into byte transfers and reassembling words.
module mem_arbiter #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(mem_arbiter_pkg::IO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full,
  output logic [1:0]        dbg_state
);
  import mem_arbiter_pkg::*;

  // Handshake: a requester raises *_req with stable operands and holds it
  // until the matching *_done pulse; done is a single-cycle strobe (only
  // issued while rdy is high) and the arbiter never grants in a done cycle.

  arb_state_e        state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [2:0]        len, len_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       wdata_q, wdata_n;
  logic              if_done_q, if_done_n;
  logic              mem_done_q, mem_done_n;
  logic [31:0]       if_inst_n, mem_rdata_n;
  logic              grant;
  logic              capture;
  logic [31:0]       word_merged;
  logic [ADDR_W-1:0] ram_a_c;
  logic              ram_wr_c;
  logic [7:0]        ram_dout_c;

  mem_arbiter_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .en          (rdy),
    .clear       (grant),
    .capture     (capture),
    .idx         (2'(cnt - 3'd1)),
    .din         (ram_din),
    .word_merged (word_merged)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      len        <= 3'd0;
      base       <= '0;
      wdata_q    <= ZeroWord;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if_inst    <= ZeroWord;
      mem_rdata  <= ZeroWord;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      len        <= len_n;
      base       <= base_n;
      wdata_q    <= wdata_n;
      if_done_q  <= if_done_n;
      mem_done_q <= mem_done_n;
      if_inst    <= if_inst_n;
      mem_rdata  <= mem_rdata_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    len_n       = len;
    base_n      = base;
    wdata_n     = wdata_q;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    if_inst_n   = if_inst;
    mem_rdata_n = mem_rdata;
    grant       = 1'b0;
    capture     = 1'b0;
    ram_a_c     = '0;
    ram_wr_c    = 1'b0;
    ram_dout_c  = 8'h00;
    cur_addr    = base + ADDR_W'(cnt);

    unique case (state)
      IDLE: begin
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            grant   = 1'b1;
            state_n = mem_we ? WRITE : MEM_READ;
            base_n  = mem_addr;
            len_n   = mem_len;
            wdata_n = mem_wdata;
            cnt_n   = 3'd0;
          end else if (if_req && !if_flush) begin
            grant   = 1'b1;
            state_n = IF_READ;
            base_n  = if_addr;
            len_n   = LEN_W;
            cnt_n   = 3'd0;
          end
        end
      end

      IF_READ, MEM_READ: begin
        capture = (cnt != 3'd0);
        // While frozen, re-present the previous address so that ram_din still
        // carries byte cnt-1 on the first cycle after rdy returns.
        if (!rdy && cnt != 3'd0) begin
          ram_a_c = base + ADDR_W'(cnt - 3'd1);
        end else if (cnt < len) begin
          ram_a_c = cur_addr;
        end

        if (state == IF_READ && if_flush) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end else if (cnt >= len) begin
          state_n = IDLE;
          cnt_n   = 3'd0;
          if (state == IF_READ) begin
            if_done_n = 1'b1;
            if_inst_n = word_merged;
          end else begin
            mem_done_n  = 1'b1;
            mem_rdata_n = word_merged;
          end
        end else begin
          cnt_n = cnt + 3'd1;
        end
      end

      WRITE: begin
        if (cnt < len) begin
          ram_a_c    = cur_addr;
          ram_dout_c = wdata_q[8*cnt[1:0] +: 8];
          if (!(cur_addr >= IO_BASE && io_buffer_full)) begin
            ram_wr_c = 1'b1;
            cnt_n    = cnt + 3'd1;
          end
        end else begin
          state_n    = IDLE;
          cnt_n      = 3'd0;
          mem_done_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign ram_a     = ram_a_c;
  assign ram_dout  = ram_dout_c;
  assign ram_wr    = ram_wr_c & rdy;
  assign if_done   = if_done_q & rdy & ~if_flush;
  assign mem_done  = mem_done_q & rdy;
  assign dbg_state = state;

endmodule
